// File: rtl/aemb_intc_pkg.sv
// Shared constants and helpers for the aeMB interrupt controller.
package aemb_intc_pkg;

   // Word addresses of the register file.
   localparam logic [2:0] ADR_ISR = 3'd0;
   localparam logic [2:0] ADR_IPR = 3'd1;
   localparam logic [2:0] ADR_IER = 3'd2;
   localparam logic [2:0] ADR_IAR = 3'd3;
   localparam logic [2:0] ADR_IVR = 3'd4;
   localparam logic [2:0] ADR_MER = 3'd5;

   // IVR value when nothing is pending.
   localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;

   // Expand the four byte-lane enables into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         m[8*k +: 8] = {8{sel[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/aemb_intc_sync.sv
// Per-source 2-flop synchroniser followed by a history flop.
// s is the synchronised level, rise pulses for one cycle on a 0->1 change of s.
module aemb_intc_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] s,
   output logic [W-1:0] rise
);

   logic [W-1:0] meta;
   logic [W-1:0] hist;

   // Synchroniser chain plus one cycle of history for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         s    <= '0;
         hist <= '0;
      end else begin
         meta <= d;
         s    <= meta;
         hist <= s;
      end
   end

   assign rise = s & ~hist;

endmodule

// File: rtl/aemb_intc.sv
// Wishbone-slave interrupt controller: collects up to 32 sources into one
// registered interrupt line with a guaranteed low gap after each acknowledge.
module aemb_intc
   import aemb_intc_pkg::*;
#(
   parameter int          IRQN = 8,
   parameter logic [31:0] EDGE = 32'hFFFF_FFFF
) (
   input  logic            sys_clk_i,
   input  logic            sys_rst_i,
   input  logic [IRQN-1:0] irq_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [2:0]      wb_adr_i,
   input  logic [3:0]      wb_sel_i,
   input  logic [31:0]     wb_dat_i,
   output logic [31:0]     wb_dat_o,
   output logic            wb_ack_o,
   output logic            sys_int_o
);

   // Bits that exist; everything above IRQN reads 0 and ignores writes.
   localparam logic [31:0] VALID  = (IRQN >= 32) ? 32'hFFFF_FFFF
                                                 : ((32'd1 << IRQN) - 32'd1);
   localparam logic [31:0] EDGE_M = EDGE & VALID;
   localparam logic [31:0] LVL_M  = ~EDGE & VALID;

   logic [IRQN-1:0] s_n;
   logic [IRQN-1:0] rise_n;
   logic [31:0]     s_w;
   logic [31:0]     rise_w;

   logic [31:0] isr;
   logic [31:0] ier;
   logic        mer;
   logic [1:0]  gap;

   logic        bus_go;
   logic        wr;
   logic [31:0] bm;
   logic [31:0] clr;
   logic [31:0] isr_nxt;
   logic [31:0] ier_nxt;
   logic [31:0] ipr;
   logic [31:0] ivr;
   logic [31:0] rd_mux;

   // Index of the lowest set bit, or the "none" value when empty.
   function automatic logic [31:0] lowest_set(input logic [31:0] v);
      logic [31:0] r;
      r = IVR_NONE;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) r = 32'(i);
      end
      return r;
   endfunction

   aemb_intc_sync #(
      .W (IRQN)
   ) u_sync (
      .clk  (sys_clk_i),
      .rst  (sys_rst_i),
      .d    (irq_i),
      .s    (s_n),
      .rise (rise_n)
   );

   // Widen the synchronised source vectors to the 32-bit register width.
   always_comb begin
      s_w              = '0;
      rise_w           = '0;
      s_w[IRQN-1:0]    = s_n;
      rise_w[IRQN-1:0] = rise_n;
   end

   // Bus decode, next-state of status/enable and the read multiplexer.
   always_comb begin
      bus_go = wb_stb_i & ~wb_ack_o;
      wr     = bus_go & wb_we_i;
      bm     = lane_mask(wb_sel_i) & VALID;

      clr = '0;
      if (wr && (wb_adr_i == ADR_ISR || wb_adr_i == ADR_IAR)) begin
         clr = wb_dat_i & bm & EDGE_M;
      end

      // Edge bits latch rises and a same-cycle rise beats the clear;
      // level bits simply track the synchronised input.
      isr_nxt = (((isr & ~clr) | rise_w) & EDGE_M) | (s_w & LVL_M);

      ier_nxt = ier;
      if (wr && wb_adr_i == ADR_IER) begin
         ier_nxt = (ier & ~bm) | (wb_dat_i & bm);
      end

      ipr = isr & ier;
      ivr = lowest_set(ipr);

      rd_mux = '0;
      case (wb_adr_i)
         ADR_ISR: rd_mux = isr;
         ADR_IPR: rd_mux = ipr;
         ADR_IER: rd_mux = ier;
         ADR_IVR: rd_mux = ivr;
         ADR_MER: rd_mux = {31'd0, mer};
         default: rd_mux = '0;
      endcase
   end

   // Register file and bus handshake; writes commit on the edge raising ack.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         isr      <= '0;
         ier      <= '0;
         mer      <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         isr      <= isr_nxt;
         ier      <= ier_nxt;
         if (wr && wb_adr_i == ADR_MER && wb_sel_i[0]) begin
            mer <= wb_dat_i[0];
         end
         wb_ack_o <= bus_go;
         wb_dat_o <= bus_go ? rd_mux : 32'd0;
      end
   end

   // Output shaping: an acknowledge forces at least two low cycles so the
   // core's rising-edge latch sees a fresh edge for anything still pending.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         gap       <= 2'd0;
         sys_int_o <= 1'b0;
      end else begin
         if (wr && wb_adr_i == ADR_IAR) begin
            gap <= 2'd2;
         end else if (gap != 2'd0) begin
            gap <= gap - 2'd1;
         end
         sys_int_o <= mer & (|ipr) & (gap == 2'd0);
      end
   end

endmodule

// File: tb/tb_aemb_intc.sv
// Directed testbench for aemb_intc with hand-computed expectations.
module tb_aemb_intc;

   localparam logic [2:0] A_ISR = 3'd0;
   localparam logic [2:0] A_IPR = 3'd1;
   localparam logic [2:0] A_IER = 3'd2;
   localparam logic [2:0] A_IAR = 3'd3;
   localparam logic [2:0] A_IVR = 3'd4;
   localparam logic [2:0] A_MER = 3'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq;
   logic        stb;
   logic        we;
   logic [2:0]  adr;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        int_o;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aemb_intc #(
      .IRQN (8),
      .EDGE (32'hFFFF_FFF7)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .irq_i     (irq),
      .wb_stb_i  (stb),
      .wb_we_i   (we),
      .wb_adr_i  (adr),
      .wb_sel_i  (sel),
      .wb_dat_i  (dat_w),
      .wb_dat_o  (dat_r),
      .wb_ack_o  (ack),
      .sys_int_o (int_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus transfer; returns #1 after the edge that raised ack.
   // Reads keep strobe one more edge to confirm ack is a single cycle.
   task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
      bit seen;
      seen = 0;
      rd   = '0;
      @(negedge clk);
      stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            seen = 1;
            rd   = dat_r;
         end
      end
      check("ack_seen", {31'd0, seen}, 32'd1);
      if (!w) begin
         @(posedge clk); #1;
         check("ack_one_cycle", {31'd0, ack}, 32'd0);
      end
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] unused_rd;
      xfer(1'b1, a, d, s, unused_rd);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] v;
      xfer(1'b0, a, 32'd0, 4'hF, v);
      check(tag, v, exp);
   endtask

   // irq high across exactly one rising edge; returns at the following negedge.
   task automatic pulse(input int idx);
      @(negedge clk); irq[idx] = 1'b1;
      @(negedge clk); irq[idx] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq = '0; stb = 1'b0; we = 1'b0;
      adr = '0; sel = '0; dat_w = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_int", {31'd0, int_o}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Reset values at every address.
      rd_chk("r_isr", A_ISR, 32'd0);
      rd_chk("r_ipr", A_IPR, 32'd0);
      rd_chk("r_ier", A_IER, 32'd0);
      rd_chk("r_iar", A_IAR, 32'd0);
      rd_chk("r_ivr", A_IVR, 32'hFFFF_FFFF);
      rd_chk("r_mer", A_MER, 32'd0);
      rd_chk("r_a6",  3'd6,  32'd0);
      rd_chk("r_a7",  3'd7,  32'd0);

      // Enable masking of bits above IRQN and byte lanes.
      wr(A_IER, 32'hFFFF_FF05, 4'hF);
      rd_chk("ier_mask", A_IER, 32'h0000_0005);
      wr(A_IER, 32'h0000_0000, 4'hE);
      rd_chk("ier_lane", A_IER, 32'h0000_0005);
      wr(A_MER, 32'hFFFF_FFFF, 4'hF);
      rd_chk("mer", A_MER, 32'd1);

      // Edge source 2: four edges from pulse to interrupt.
      pulse(2);
      @(posedge clk);
      @(posedge clk); #1;
      check("int_e3", {31'd0, int_o}, 32'd0);
      @(posedge clk); #1;
      check("int_e4", {31'd0, int_o}, 32'd1);
      rd_chk("isr_4", A_ISR, 32'd4);
      rd_chk("ipr_4", A_IPR, 32'd4);
      rd_chk("ivr_2", A_IVR, 32'd2);

      // Disabled source 1 shows in ISR but not IPR.
      pulse(1);
      repeat (3) @(posedge clk);
      #1;
      rd_chk("isr_6", A_ISR, 32'd6);
      rd_chk("ipr_4b", A_IPR, 32'd4);

      // Two pending: lowest wins; IAR clears and forces a two-cycle gap.
      pulse(0);
      repeat (3) @(posedge clk);
      #1;
      rd_chk("ivr_0", A_IVR, 32'd0);
      wr(A_IAR, 32'd1, 4'hF);
      check("gap_k0", {31'd0, int_o}, 32'd1);
      @(posedge clk); #1;
      check("gap_k1", {31'd0, int_o}, 32'd0);
      @(posedge clk); #1;
      check("gap_k2", {31'd0, int_o}, 32'd0);
      @(posedge clk); #1;
      check("gap_k3", {31'd0, int_o}, 32'd1);
      rd_chk("ivr_2b", A_IVR, 32'd2);
      rd_chk("isr_6b", A_ISR, 32'd6);

      // Level source 3.
      wr(A_ISR, 32'd6, 4'hF);
      rd_chk("isr_clr", A_ISR, 32'd0);
      wr(A_IER, 32'h0D, 4'h1);
      @(negedge clk); irq[3] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("lvl_int", {31'd0, int_o}, 32'd1);
      rd_chk("lvl_isr", A_ISR, 32'd8);
      wr(A_ISR, 32'd8, 4'hF);
      rd_chk("lvl_keep", A_ISR, 32'd8);
      @(negedge clk); irq[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("lvl_e3", {31'd0, int_o}, 32'd1);
      @(posedge clk); #1;
      check("lvl_e4", {31'd0, int_o}, 32'd0);
      rd_chk("lvl_gone", A_ISR, 32'd0);

      // Rise of source 0 on the same edge as an IAR clear of bit 0: set wins.
      @(negedge clk); irq[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stb = 1'b1; we = 1'b1; adr = A_IAR; dat_w = 32'd1; sel = 4'hF;
      @(posedge clk); #1;
      check("race_ack", {31'd0, ack}, 32'd1);
      stb = 1'b0; we = 1'b0; irq[0] = 1'b0;
      rd_chk("race_isr", A_ISR, 32'd1);

      // Master disable drops the output next cycle, ISR retained.
      @(posedge clk); #1;
      check("mer_pre", {31'd0, int_o}, 32'd1);
      wr(A_MER, 32'd0, 4'h1);
      check("mer_k0", {31'd0, int_o}, 32'd1);
      @(posedge clk); #1;
      check("mer_k1", {31'd0, int_o}, 32'd0);
      rd_chk("mer_isr", A_ISR, 32'd1);
      rd_chk("mer_0", A_MER, 32'd0);

      // Asynchronous reset during an acked read.
      @(negedge clk);
      stb = 1'b1; we = 1'b0; adr = A_ISR; sel = 4'hF;
      @(posedge clk); #1;
      check("arst_ack_pre", {31'd0, ack}, 32'd1);
      check("arst_dat_pre", dat_r, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_ack", {31'd0, ack}, 32'd0);
      check("arst_dat", dat_r, 32'd0);
      stb = 1'b0;
      @(negedge clk); rst = 1'b0;
      rd_chk("arst_isr", A_ISR, 32'd0);
      rd_chk("arst_ier", A_IER, 32'd0);
      rd_chk("arst_mer", A_MER, 32'd0);
      rd_chk("arst_ivr", A_IVR, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/aemb_intc.md
# aemb_intc

Wishbone-slave interrupt controller on the aeMB data bus. Aggregates up to 32 peripheral interrupt sources into the single `sys_int_i` line consumed by the core's system control unit. It:
- synchronises and edge- or level-detects each source;
- keeps status, enable, acknowledge and vector registers;
- shapes its output so every new pending interrupt gives the core a clean rising edge.

## Interface
Parameters:
- `IRQN`, 8: number of interrupt sources, 1..32.
- `EDGE`, 32'hFFFFFFFF: per-source mode mask; 1 = rising-edge latched, 0 = level.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk_i`  in  1  system clock.
- `sys_rst_i`  in  1  asynchronous active-high reset.
- `irq_i`  in  IRQN  raw peripheral interrupt requests, asynchronous.
- `wb_stb_i`  in  1  bus strobe, held until ack.
- `wb_we_i`  in  1  write enable.
- `wb_adr_i`  in  3  word address, byte address bits [4:2].
- `wb_sel_i`  in  4  byte lane enables; `sel[k]` enables bits [8k+7:8k].
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `wb_ack_o`  out  1  single-cycle acknowledge, registered.
- `sys_int_o`  out  1  interrupt to core, registered.

## Operation
Register map (`wb_adr_i`):
- 0 ISR: status.
  - Read: pending bits.
  - Write-1-to-clear, edge sources only; level bits ignore writes.
- 1 IPR: read-only, ISR & IER.
- 2 IER: enable, read/write.
- 3 IAR: write-1-to-clear ISR bits (same effect as an ISR write) and start the output gap. Reads 0.
- 4 IVR: read-only. Index of the lowest-numbered set IPR bit, zero-extended; 32'hFFFFFFFF when IPR == 0.
- 5 MER: bit0 master enable, read/write; other bits read 0.
- 6, 7: reads 0, writes ignored.

Register and source rules:
- Bits at or above IRQN read 0 and ignore writes.
- Each `irq_i` bit passes through a 2-flop synchroniser giving `s`, then a history flop giving `p`.
- Edge source: ISR bit set when `s & !p`.
- Level source: ISR bit = `s`, continuously.
- Same-cycle set and clear of an ISR bit: set wins.

Output shaping (`sys_int_o`):
- Next value = MER[0] & |IPR & (gap == 0).
- Gap counter (2 bits) loads 2 on any acked IAR write, then decrements to 0.
- The gap guarantees at least 2 low cycles, so a remaining or new pending source re-triggers the core's rising-edge latch.
- Writing MER[0]=0 drops `sys_int_o` on the next cycle. Pending ISR bits are retained.

## Timing
Bus handshake:
- `wb_ack_o` next = `wb_stb_i & !wb_ack_o`: asserted the cycle after strobe is seen, high for exactly one cycle.
- Back-to-back strobes are acked every other cycle.
- Writes commit on the same edge that raises `wb_ack_o`.
- `wb_dat_o` is valid while `wb_ack_o` is high and reflects register state before that edge's updates.

Latencies:
- `irq_i` rising to ISR set: 3 edges (2 synchroniser, 1 detect).
- ISR set to `sys_int_o` high: 1 more edge.
- Acked write to IER/MER/ISR: `sys_int_o` follows 1 edge later.
- IAR write: `sys_int_o` low for edges +1 and +2; may rise at +3.

Reset (asynchronous): all flops 0. Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `sys_int_o`=0, ISR=IER=MER=0, gap=0. Reset mid-transfer drops ack; the master re-issues the transfer.

## Structure
- Package `aemb_intc_pkg` holds the address constants (ISR..MER) and the IVR "none" value 32'hFFFFFFFF.
- One natural sub-module: `aemb_intc_sync`, the per-bit 2-flop synchroniser plus history flop, width parameterised, outputting `s` and the rise pulse.
- Priority encoder, register file and bus logic stay in the top module.

## Test plan
- Reset, then read all 8 addresses: ISR/IPR/IER/MER/IAR = 0, IVR = 32'hFFFFFFFF, addresses 6/7 = 0, and each ack is exactly one cycle.
- IER=8'h05, MER=1, pulse `irq_i[2]` for 1 cycle: ISR=4, IPR=4, IVR=2, `sys_int_o` high 4 edges after the pulse. Pulse `irq_i[1]`: ISR=6, IPR stays 4.
- Pending bits 0 and 2 both enabled: IVR=0; write IAR=1; `sys_int_o` low exactly 2 cycles, then high; IVR=2.
- Level source (EDGE bit3=0): hold `irq_i[3]` high, write ISR=8: bit stays set. Drop `irq_i[3]`: bit clears 3 edges later and `sys_int_o` falls.
- `irq_i[0]` edge arriving on the same edge as an IAR write of bit 0: ISR bit0 remains 1.
- `sys_int_o` high, then write MER=0: `sys_int_o` low next cycle, ISR unchanged. Then assert `sys_rst_i` asynchronously during a strobe: ack and all registers 0 immediately.
